// File: rtl/uart_tx_if.sv
// Byte-stream handshake and line outputs shared by the UART transmitter and its producer.
// FIFO_DEPTH must match the transmitter's FIFO_DEPTH so the count width lines up.
interface uart_tx_if #(
  parameter int FIFO_DEPTH = 4
);
  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

  logic [7:0]       i_data;
  logic             i_valid;
  logic             o_ready;
  logic             o_tx;
  logic             o_busy;
  logic [CNT_W-1:0] o_fifo_count;

  modport master (
    output i_data, i_valid,
    input  o_ready, o_tx, o_busy, o_fifo_count
  );

  modport slave (
    input  i_data, i_valid,
    output o_ready, o_tx, o_busy, o_fifo_count
  );
endinterface

// File: rtl/uart_tx.sv
// 8N1/8N2 UART transmitter with a small push FIFO in front of the shift register.
// Frames run back to back while the FIFO holds data; o_tx is driven straight from a flop.
module uart_tx #(
  parameter int input_clk_hz = 12_000_000,
  parameter int baud_rate    = 9600,
  parameter int STOP_BITS    = 1,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic      i_clk,
  input  logic      i_rst,
  uart_tx_if.slave  bus
);
  localparam int BIT_CLKS = input_clk_hz / baud_rate;
  localparam int BAUD_W   = (BIT_CLKS > 1) ? $clog2(BIT_CLKS) : 1;
  localparam int PTR_W    = $clog2(FIFO_DEPTH);
  localparam int CNT_W    = PTR_W + 1;

  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(BIT_CLKS - 1);
  localparam logic [2:0]        STOP_LAST = 3'(STOP_BITS - 1);
  localparam logic [CNT_W-1:0]  CNT_FULL  = CNT_W'(FIFO_DEPTH);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_START = 2'd1;
  localparam logic [1:0] S_DATA  = 2'd2;
  localparam logic [1:0] S_STOP  = 2'd3;

  logic [1:0]        state_q,    state_d;
  logic [BAUD_W-1:0] baud_cnt_q, baud_cnt_d;
  logic [2:0]        bit_idx_q,  bit_idx_d;
  logic [7:0]        shift_q,    shift_d;
  logic              tx_q,       tx_d;
  logic [PTR_W-1:0]  wr_ptr_q,   wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q,   rd_ptr_d;
  logic [CNT_W-1:0]  count_q,    count_d;
  logic [7:0]        mem_q [FIFO_DEPTH];
  logic [7:0]        mem_d [FIFO_DEPTH];

  logic       push;
  logic       pop;
  logic       fifo_nonempty;
  logic       bit_done;
  logic [7:0] fifo_head;

  assign bus.o_ready      = i_rst && (count_q < CNT_FULL);
  assign bus.o_tx         = tx_q;
  assign bus.o_busy       = (state_q != S_IDLE);
  assign bus.o_fifo_count = count_q;

  assign push          = bus.i_valid && bus.o_ready;
  assign fifo_nonempty = (count_q != '0);
  assign bit_done      = (baud_cnt_q == BAUD_LAST);
  assign fifo_head     = mem_q[rd_ptr_q];

  // Line sequencer: every bit boundary restarts the baud counter.
  always_comb begin
    state_d    = state_q;
    baud_cnt_d = baud_cnt_q + 1'b1;
    bit_idx_d  = bit_idx_q;
    shift_d    = shift_q;
    tx_d       = tx_q;
    pop        = 1'b0;
    case (state_q)
      S_IDLE: begin
        baud_cnt_d = '0;
        tx_d       = 1'b1;
        if (fifo_nonempty) begin
          pop     = 1'b1;
          shift_d = fifo_head;
          tx_d    = 1'b0;
          state_d = S_START;
        end
      end
      S_START: begin
        if (bit_done) begin
          baud_cnt_d = '0;
          tx_d       = shift_q[0];
          shift_d    = {1'b0, shift_q[7:1]};
          bit_idx_d  = '0;
          state_d    = S_DATA;
        end
      end
      S_DATA: begin
        if (bit_done) begin
          baud_cnt_d = '0;
          if (bit_idx_q == 3'd7) begin
            tx_d      = 1'b1;
            bit_idx_d = '0;
            state_d   = S_STOP;
          end else begin
            tx_d      = shift_q[0];
            shift_d   = {1'b0, shift_q[7:1]};
            bit_idx_d = bit_idx_q + 1'b1;
          end
        end
      end
      S_STOP: begin
        if (bit_done) begin
          baud_cnt_d = '0;
          if (bit_idx_q == STOP_LAST) begin
            bit_idx_d = '0;
            // Chain straight into the next start bit so queued bytes leave no idle gap.
            if (fifo_nonempty) begin
              pop     = 1'b1;
              shift_d = fifo_head;
              tx_d    = 1'b0;
              state_d = S_START;
            end else begin
              tx_d    = 1'b1;
              state_d = S_IDLE;
            end
          end else begin
            bit_idx_d = bit_idx_q + 1'b1;
          end
        end
      end
      default: begin
        baud_cnt_d = '0;
        tx_d       = 1'b1;
        state_d    = S_IDLE;
      end
    endcase
  end

  // Push is gated by o_ready and pop by non-empty, so the count cannot leave 0..FIFO_DEPTH.
  always_comb begin
    mem_d = mem_q;
    if (push) begin
      mem_d[wr_ptr_q] = bus.i_data;
    end
    wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      state_q    <= S_IDLE;
      baud_cnt_q <= '0;
      bit_idx_q  <= '0;
      shift_q    <= '0;
      tx_q       <= 1'b1;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
    end else begin
      state_q    <= state_d;
      baud_cnt_q <= baud_cnt_d;
      bit_idx_q  <= bit_idx_d;
      shift_q    <= shift_d;
      tx_q       <= tx_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
    end
  end

  always_ff @(posedge i_clk) begin
    mem_q <= mem_d;
  end
endmodule

// File: doc/uart_tx.md
UART_TX -- requirements
Module: uart_tx

Interface
REQ-001 SHALL have parameter input_clk_hz, default 12_000_000, input clock frequency in Hz.
REQ-002 SHALL have parameter baud_rate, default 9600, line bit rate.
REQ-003 SHALL have parameter STOP_BITS, default 1, number of stop bits; legal values 1 or 2.
REQ-004 SHALL have parameter FIFO_DEPTH, default 4, transmit FIFO entries; power of 2, at least 2.
REQ-005 SHALL have port i_clk  input  1  sole clock; all logic on the rising edge.
REQ-006 SHALL have port i_rst  input  1  reset; synchronous, active-low.
REQ-007 SHALL have port i_data  input  8  byte to transmit.
REQ-008 SHALL have port i_valid  input  1  i_data valid this cycle.
REQ-009 SHALL have port o_ready  output  1  FIFO can accept a byte this cycle.
REQ-010 SHALL have port o_tx  output  1  serial line; idle high; registered.
REQ-011 SHALL have port o_busy  output  1  a frame is on the line (state not IDLE).
REQ-012 SHALL have port o_fifo_count  output  $clog2(FIFO_DEPTH)+1  bytes queued, excluding the byte being shifted.

Function
REQ-013 SHALL use bit period BIT_CLKS = input_clk_hz / baud_rate (integer division), with every line bit held exactly BIT_CLKS clocks.
REQ-014 SHALL frame each byte as: 1 start bit (0), 8 data bits LSB first, then STOP_BITS stop bits (1); no parity.
REQ-015 SHALL accept a byte on any rising edge where i_valid=1 and o_ready=1; a byte offered with o_ready=0 SHALL be ignored, not latched.
REQ-016 SHALL drive o_ready = 1 when o_fifo_count < FIFO_DEPTH and i_rst=1; otherwise 0.
REQ-017 SHALL implement states IDLE, START, DATA, STOP.
REQ-018 IDLE: o_tx=1; when o_fifo_count != 0, SHALL pop the oldest byte into the shift register, drive o_tx=0 and enter START on the same edge.
REQ-019 START -> DATA after BIT_CLKS clocks; DATA -> STOP after 8 x BIT_CLKS clocks; STOP lasts STOP_BITS x BIT_CLKS clocks.
REQ-020 At the end of STOP, if the FIFO is non-empty, SHALL pop and start the next start bit on that edge, with no idle gap; otherwise SHALL return to IDLE.
REQ-021 Latency: a byte accepted at edge N into an empty FIFO with state IDLE SHALL produce o_tx falling at edge N+1.
REQ-022 Simultaneous push and pop on one edge SHALL leave o_fifo_count unchanged and preserve FIFO order.
REQ-023 FIFO pointers SHALL wrap modulo FIFO_DEPTH; o_fifo_count SHALL never exceed FIFO_DEPTH or underflow below 0.
REQ-024 i_data and i_valid changes during a frame SHALL NOT affect the frame in progress.

Reset
REQ-025 While i_rst=0 at an edge, the block SHALL set o_tx=1, state IDLE, o_busy=0, o_fifo_count=0, FIFO pointers 0, and clear bit/baud counters; o_ready=0.
REQ-026 Reset mid-frame SHALL abort the frame (o_tx=1 from the next edge) and discard all queued bytes.
REQ-027 On the first edge after i_rst returns to 1, o_ready SHALL be 1 and no frame SHALL start until a new byte is accepted.

Verification (bench params: input_clk_hz=160, baud_rate=10, so BIT_CLKS=16)
REQ-028 Reset: hold i_rst=0 for 3 clocks -> o_tx=1, o_busy=0, o_fifo_count=0, o_ready=0; after release, o_ready=1.
REQ-029 Single byte 0xA5, STOP_BITS=1 -> o_tx falls 1 clock after accept; o_tx sequence 0,1,0,1,0,0,1,0,1,1 with each bit 16 clocks (160 clocks total); o_busy then 0.
REQ-030 Burst: offer 0x01..0x06 on 6 consecutive edges with i_valid=1 -> 0x01..0x05 accepted (0x01 popped immediately); o_ready=0 at the 0x06 edge with o_fifo_count=4; 0x06 not transmitted.
REQ-031 Back-to-back: the 5 queued bytes are transmitted in order 0x01..0x05 with no idle clock between the last stop bit and the next start bit; o_busy stays 1 throughout (800 clocks).
REQ-032 STOP_BITS=2, byte 0xFF -> start bit 16 clocks low, then 1 high for 160 clocks; the next queued byte's start bit begins exactly 176 clocks after the first start bit.
REQ-033 Reset mid-frame: drive i_rst=0 for 1 clock during data bit 3 with 2 bytes queued -> o_tx=1 on the next edge, o_fifo_count=0, and o_tx stays 1 for 500 clocks after release.
